// File: rtl/core_info_regs.sv
// Multi-channel ZX-UNO byte-string registers: each channel is a small RAM walked by
// an auto-advancing index, one step per register access regardless of strobe length.

module core_info_chan #(
    parameter int DEPTH = 16,
    parameter int WRAP  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_hit,
    input  logic       i_rd,
    input  logic       i_wr,
    input  logic       i_addr_chg,
    input  logic [7:0] i_din,
    output logic [7:0] o_rdata
);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

    state_t          r_state, w_state_nxt;
    logic [IW-1:0]   r_idx, w_idx_nxt, w_idx_inc;
    logic            w_acc;
    // Storage powers up cleared and is deliberately outside the reset domain.
    logic [7:0]      r_mem [DEPTH] = '{default: 8'h00};

    assign w_acc     = i_hit & (i_rd | i_wr);
    assign w_idx_inc = (r_idx == IW'(DEPTH - 1)) ? ((WRAP != 0) ? '0 : r_idx)
                                                 : r_idx + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        if (i_addr_chg && i_hit) begin
            // Re-selecting the register rewinds the string and cancels any pending advance.
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE:   if (w_acc) w_state_nxt = ST_ACCESS;
                ST_ACCESS: if (!w_acc) begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = w_idx_inc;
                end
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Every strobe cycle rewrites the current slot, so the last byte of a long write wins.
    always_ff @(posedge clk) begin
        if (i_hit && i_wr) r_mem[r_idx] <= i_din;
    end

    assign o_rdata = r_mem[r_idx];
endmodule

module core_info_regs #(
    parameter int         NCHAN    = 2,
    parameter int         DEPTH    = 16,
    parameter logic [7:0] BASEADDR = 8'hFE,
    parameter int         WRAP     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] zxuno_addr,
    input  logic       zxuno_regrd,
    input  logic       zxuno_regwr,
    input  logic       regaddr_changed,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       oe_n
);
    logic [NCHAN-1:0]      w_hit;
    logic [NCHAN-1:0][7:0] w_rdata;
    logic [7:0]            w_sel;
    logic [7:0]            r_dout;

    for (genvar k = 0; k < NCHAN; k++) begin : g_chan
        localparam logic [7:0] CH_ADDR = BASEADDR + 8'(k);
        assign w_hit[k] = (zxuno_addr == CH_ADDR);

        core_info_chan #(.DEPTH(DEPTH), .WRAP(WRAP)) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_hit      (w_hit[k]),
            .i_rd       (zxuno_regrd),
            .i_wr       (zxuno_regwr),
            .i_addr_chg (regaddr_changed),
            .i_din      (din),
            .o_rdata    (w_rdata[k])
        );
    end

    // Channel addresses are distinct, so at most one hit is ever set.
    always_comb begin
        w_sel = 8'h00;
        for (int k = 0; k < NCHAN; k++)
            if (w_hit[k]) w_sel = w_rdata[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_dout <= 8'h00;
        else        r_dout <= w_sel;
    end

    assign dout = r_dout;
    assign oe_n = ~((|w_hit) & zxuno_regrd & ~zxuno_regwr);
endmodule

// File: doc/core_info_regs.md
CORE_INFO_REGS -- requirements
Module: core_info_regs

Interface
REQ-001 The block SHALL have parameter NCHAN, default 2, meaning the number of independent byte strings (1..4).
REQ-002 The block SHALL have parameter DEPTH, default 16, meaning the bytes per string (power of two, 4..64).
REQ-003 The block SHALL have parameter BASEADDR, default 8'hFE, meaning channel k is the ZX-UNO register BASEADDR+k (BASEADDR+NCHAN-1 <= 8'hFF).
REQ-004 The block SHALL have parameter WRAP, default 1, meaning 1 = index wraps to 0 after DEPTH-1 and 0 = index saturates at DEPTH-1.
REQ-005 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port zxuno_addr, input, 8 bits: the currently selected ZX-UNO register number.
REQ-008 The block SHALL have port zxuno_regrd, input, 1 bit: a register read strobe, held high for the whole read access.
REQ-009 The block SHALL have port zxuno_regwr, input, 1 bit: a register write strobe, held high for the whole write access.
REQ-010 The block SHALL have port regaddr_changed, input, 1 bit: a one-cycle pulse when zxuno_addr has just been written.
REQ-011 The block SHALL have port din, input, 8 bits: write data.
REQ-012 The block SHALL have port dout, output, 8 bits: registered read data.
REQ-013 The block SHALL have port oe_n, output, 1 bit: active-low read-data enable.

Function
REQ-014 The block SHALL define hit(k) as zxuno_addr == BASEADDR+k, and hit as hit(k) true for any k in 0..NCHAN-1.
REQ-015 The block SHALL drive oe_n combinationally low iff hit && zxuno_regrd && !zxuno_regwr.
REQ-016 The block SHALL hold NCHAN x DEPTH x 8-bit storage, zero at configuration and unaffected by rst_n.
REQ-017 The block SHALL keep a per-channel index idx[k] of width log2(DEPTH) and a per-channel 2-state FSM: IDLE, ACCESS.
REQ-018 The FSM SHALL go IDLE->ACCESS on any cycle with hit(k) && (zxuno_regrd || zxuno_regwr).
REQ-019 The FSM SHALL go ACCESS->IDLE on the first cycle without hit(k) && (zxuno_regrd || zxuno_regwr), and on that same edge SHALL advance idx[k] by one.
REQ-020 The index advance SHALL follow WRAP: with WRAP=1, DEPTH-1 -> 0; with WRAP=0, DEPTH-1 stays DEPTH-1.
REQ-021 On every cycle in which hit(k) && zxuno_regwr, the block SHALL write din to mem[k][idx[k]], so the last value wins for a multi-cycle strobe; zxuno_regwr has priority over zxuno_regrd.
REQ-022 An access SHALL advance idx exactly once, regardless of strobe length.
REQ-023 The block SHALL register dout every cycle: dout <= mem[k][idx[k]] when hit(k), else dout <= 8'h00.
REQ-024 A written byte SHALL be readable at dout on the cycle after the write.
REQ-025 A new index SHALL reach dout one cycle after idx updates.
REQ-026 regaddr_changed && hit(k) SHALL set idx[k] to 0 and FSM[k] to IDLE with no advance, overriding REQ-019 on the same cycle.
REQ-027 Channels whose address is not selected SHALL keep their idx and FSM unchanged.
REQ-028 If zxuno_addr moves from channel j to channel k mid-access, FSM[j] SHALL end the access and advance idx[j] per REQ-019, while FSM[k] enters ACCESS.

Reset
REQ-029 rst_n low SHALL immediately set every idx to 0, every FSM to IDLE, and dout to 8'h00.
REQ-030 rst_n low SHALL NOT alter storage, and oe_n SHALL remain combinational.
REQ-031 Reset asserted mid-access SHALL discard the pending advance.
REQ-032 After rst_n deasserts, the first strobe cycle SHALL begin a new access at index 0.

Verification
REQ-033 The bench SHALL, with defaults: write "AB" to channel 0 with two separate one-cycle regwr pulses at 8'hFE, pulse regaddr_changed, then do two reads -> dout 8'h41 then 8'h42, and idx[0]=2.
REQ-034 The bench SHALL hold regrd for 5 cycles on 8'hFF -> oe_n low for exactly those 5 cycles, idx[1] advances by exactly 1, and dout during the read equals mem[1][0].
REQ-035 The bench SHALL check wrap: 16 reads on channel 0 with WRAP=1 -> idx returns to 0 and the 17th read returns the byte at index 0; with WRAP=0, reads 16 and 17 both return mem[0][15].
REQ-036 The bench SHALL check the simultaneous case: regaddr_changed on the same cycle as the end of an access on 8'hFE -> idx[0]=0, with no advance.
REQ-037 The bench SHALL assert rst_n low mid-read on channel 1 (idx[1]=3) -> dout=8'h00 and idx[1]=0 asynchronously, storage intact, and the next read returns mem[1][0].
REQ-038 The bench SHALL check addr 8'hFD with regrd high -> oe_n high, dout 8'h00, and no index change on any channel.
